// File: rtl/polyvec_chknorm_stream.sv
// Streaming infinity-norm checker for a vector of up to K polynomials.
// Flags the first coefficient with |a| >= bound and always drains the whole vector.
module polyvec_chknorm_stream #(
  parameter int K       = 6,
  parameter int N       = 256,
  parameter int COEFF_W = 32,
  parameter int LANES   = 4,
  parameter int Q       = 8380417
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [31:0]                bound,
  input  logic [$clog2(K+1)-1:0]     num_poly,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*COEFF_W-1:0]   in_data,
  output logic                       busy,
  output logic                       done,
  output logic                       flag,
  output logic [$clog2(K)-1:0]       fail_poly,
  output logic [$clog2(N)-1:0]       fail_coeff
);

  localparam int BEATS = N / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(K + 1);
  localparam int FPW   = $clog2(K);
  localparam int FCW   = $clog2(N);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW    = (COEFF_W + 1 > 32) ? COEFF_W + 1 : 32;
  localparam logic signed [31:0] LIMIT = 32'((Q - 1) / 8);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t          state_r;
  logic [31:0]     bound_r;
  logic [PW-1:0]   last_poly_r;
  logic [PW-1:0]   poly_cnt_r;
  logic [BW-1:0]   beat_cnt_r;
  logic            in_ready_r, busy_r, done_r, flag_r;
  logic [FPW-1:0]  fail_poly_r;
  logic [FCW-1:0]  fail_coeff_r;

  logic [LANES-1:0] lane_fail_s;
  logic [COEFF_W:0] abs_s;
  logic [LW-1:0]    first_lane_s;
  logic             any_fail_s;
  logic             accept_s;
  logic [PW-1:0]    np_clamp_s;
  logic             bound_bad_s;
  logic [FCW-1:0]   fc_s;

  // One extra bit so the most negative coefficient has a representable magnitude
  function automatic logic [COEFF_W:0] abs_coeff(input logic [COEFF_W-1:0] a);
    logic [COEFF_W:0] ext;
    ext = {a[COEFF_W-1], a};
    return ext[COEFF_W] ? (~ext + {{COEFF_W{1'b0}}, 1'b1}) : ext;
  endfunction

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign flag       = flag_r;
  assign fail_poly  = fail_poly_r;
  assign fail_coeff = fail_coeff_r;

  assign accept_s = (state_r == RUN) && in_valid && in_ready_r;

  // Per-lane bound test and lowest failing lane of the current beat
  always_comb begin
    lane_fail_s  = {LANES{1'b0}};
    abs_s        = {(COEFF_W+1){1'b0}};
    first_lane_s = {LW{1'b0}};
    for (int j = LANES - 1; j >= 0; j--) begin
      abs_s          = abs_coeff(in_data[j*COEFF_W +: COEFF_W]);
      lane_fail_s[j] = bound_r[31] | (CW'(abs_s) >= CW'(bound_r));
      first_lane_s   = lane_fail_s[j] ? LW'(j) : first_lane_s;
    end
    any_fail_s = |lane_fail_s;
    fc_s       = FCW'(32'(beat_cnt_r) * 32'(LANES) + 32'(first_lane_s));
  end

  // Run setup: clamp the poly count and screen the bound against the legal limit
  always_comb begin
    np_clamp_s  = num_poly;
    bound_bad_s = $signed(bound) > LIMIT;
    if ((num_poly == {PW{1'b0}}) || (num_poly > PW'(K))) begin
      np_clamp_s = PW'(K);
    end else begin
      np_clamp_s = num_poly;
    end
  end

  // Control FSM with registered handshake, status and first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      bound_r      <= 32'd0;
      last_poly_r  <= {PW{1'b0}};
      poly_cnt_r   <= {PW{1'b0}};
      beat_cnt_r   <= {BW{1'b0}};
      in_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      flag_r       <= 1'b0;
      fail_poly_r  <= {FPW{1'b0}};
      fail_coeff_r <= {FCW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r      <= RUN;
            bound_r      <= bound;
            last_poly_r  <= np_clamp_s - PW'(1);
            poly_cnt_r   <= {PW{1'b0}};
            beat_cnt_r   <= {BW{1'b0}};
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b1;
            flag_r       <= bound_bad_s;
            fail_poly_r  <= {FPW{1'b0}};
            fail_coeff_r <= {FCW{1'b0}};
          end
        end
        RUN: begin
          if (accept_s) begin
            if (!flag_r && any_fail_s) begin
              flag_r       <= 1'b1;
              fail_poly_r  <= FPW'(poly_cnt_r);
              fail_coeff_r <= fc_s;
            end
            if (beat_cnt_r == BW'(BEATS - 1)) begin
              beat_cnt_r <= {BW{1'b0}};
              if (poly_cnt_r == last_poly_r) begin
                state_r    <= FIN;
                in_ready_r <= 1'b0;
                done_r     <= 1'b1;
              end else begin
                poly_cnt_r <= poly_cnt_r + PW'(1);
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + BW'(1);
            end
          end
        end
        FIN: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule
